// File: rtl/div_pkg.sv
// Shared types for the iterative divider: operation codes, FSM states and helpers.
package div_pkg;

    typedef enum logic [1:0] {
        OpDiv  = 2'b00,
        OpDivu = 2'b01,
        OpRem  = 2'b10,
        OpRemu = 2'b11
    } div_op_e;

    typedef enum logic [2:0] {
        StIdle,
        StPrep,
        StIter,
        StFix,
        StDone
    } div_state_e;

    // funct3[0] clear selects the signed variants
    function automatic logic is_signed(div_op_e op);
        return (op == OpDiv) || (op == OpRem);
    endfunction

endpackage

// File: rtl/iter_divider_if.sv
// Request/response bundle between the execute stage and the iterative divider.
interface iter_divider_if #(
    parameter int unsigned WIDTH = 32
) ();

    logic             start_i;
    logic [1:0]       op_i;
    logic [WIDTH-1:0] dividend_i;
    logic [WIDTH-1:0] divisor_i;
    logic             flush_i;
    logic             ready_o;
    logic [WIDTH-1:0] quotient_o;
    logic [WIDTH-1:0] remainder_o;
    logic             done_o;
    logic [WIDTH-1:0] result_o;

    modport master (
        output start_i, op_i, dividend_i, divisor_i, flush_i,
        input  ready_o, quotient_o, remainder_o, done_o, result_o
    );

    modport slave (
        input  start_i, op_i, dividend_i, divisor_i, flush_i,
        output ready_o, quotient_o, remainder_o, done_o, result_o
    );

endinterface

// File: rtl/div_step.sv
// One radix-2 restoring division step: shift in a dividend bit, trial-subtract, restore.
module div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             qbit_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // rem_i < divisor_i always holds, so WIDTH+1 bits cannot overflow and the MSB is the borrow
    always_comb begin
        shifted = {rem_i, bit_i};
        trial   = shifted - {1'b0, divisor_i};
        qbit_o  = ~trial[WIDTH];
        rem_o   = qbit_o ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/iter_divider.sv
// Multi-cycle RISC-V DIV/DIVU/REM/REMU unit: one quotient bit per cycle, with short-cuts
// for divide-by-zero and signed overflow.
module iter_divider import div_pkg::*; #(
    parameter int unsigned WIDTH = 32
) (
    input  logic          clk_i,
    input  logic          reset_ni,
    iter_divider_if.slave bus
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MinNeg = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_e       state_q;
    div_op_e          op_q;
    logic [WIDTH-1:0] a_q;      // dividend, then shifts into the quotient
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] rem_q;
    logic [CntW-1:0]  cnt_q;
    logic             negq_q;
    logic             negr_q;
    logic [WIDTH-1:0] quot_q;
    logic [WIDTH-1:0] remd_q;
    logic [WIDTH-1:0] res_q;
    logic             done_q;

    logic [WIDTH-1:0] step_rem;
    logic             step_bit;
    logic             a_neg;
    logic             b_neg;
    logic             overflow;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_i     (rem_q),
        .bit_i     (a_q[WIDTH-1]),
        .divisor_i (b_q),
        .rem_o     (step_rem),
        .qbit_o    (step_bit)
    );

    always_comb begin
        a_neg    = is_signed(op_q) & a_q[WIDTH-1];
        b_neg    = is_signed(op_q) & b_q[WIDTH-1];
        abs_a    = a_neg ? -a_q : a_q;
        abs_b    = b_neg ? -b_q : b_q;
        overflow = is_signed(op_q) && (a_q == MinNeg) && (b_q == '1);
        q_fix    = negq_q ? -a_q : a_q;
        r_fix    = negr_q ? -rem_q : rem_q;
    end

    function automatic logic [WIDTH-1:0] pick(div_op_e op, logic [WIDTH-1:0] q,
                                              logic [WIDTH-1:0] r);
        return ((op == OpRem) || (op == OpRemu)) ? r : q;
    endfunction

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= StIdle;
            op_q    <= OpDiv;
            a_q     <= '0;
            b_q     <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            quot_q  <= '0;
            remd_q  <= '0;
            res_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.start_i) begin
                        op_q    <= div_op_e'(bus.op_i);
                        a_q     <= bus.dividend_i;
                        b_q     <= bus.divisor_i;
                        state_q <= StPrep;
                    end
                end
                StPrep: begin
                    if (bus.flush_i) begin
                        state_q <= StIdle;
                    end else if (b_q == '0) begin
                        quot_q  <= '1;
                        remd_q  <= a_q;
                        res_q   <= pick(op_q, '1, a_q);
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end else if (overflow) begin
                        quot_q  <= a_q;
                        remd_q  <= '0;
                        res_q   <= pick(op_q, a_q, '0);
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        a_q     <= abs_a;
                        b_q     <= abs_b;
                        rem_q   <= '0;
                        cnt_q   <= CntW'(WIDTH - 1);
                        negq_q  <= a_neg ^ b_neg;
                        negr_q  <= a_neg;
                        state_q <= StIter;
                    end
                end
                StIter: begin
                    if (bus.flush_i) begin
                        state_q <= StIdle;
                    end else begin
                        rem_q <= step_rem;
                        a_q   <= {a_q[WIDTH-2:0], step_bit};
                        cnt_q <= cnt_q - CntW'(1);
                        if (cnt_q == '0) begin
                            state_q <= StFix;
                        end
                    end
                end
                StFix: begin
                    if (bus.flush_i) begin
                        state_q <= StIdle;
                    end else begin
                        quot_q  <= q_fix;
                        remd_q  <= r_fix;
                        res_q   <= pick(op_q, q_fix, r_fix);
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    if (bus.flush_i) begin
                        state_q <= StIdle;
                    end else if (bus.start_i) begin
                        op_q    <= div_op_e'(bus.op_i);
                        a_q     <= bus.dividend_i;
                        b_q     <= bus.divisor_i;
                        state_q <= StPrep;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.ready_o     = (state_q == StIdle) || (state_q == StDone);
    assign bus.done_o      = done_q;
    assign bus.quotient_o  = quot_q;
    assign bus.remainder_o = remd_q;
    assign bus.result_o    = res_q;

endmodule

// File: tb/tb_iter_divider.sv
// Self-checking bench for iter_divider: directed cases plus random ops against an
// arithmetic reference model.
module tb_iter_divider;

    logic clk;
    logic reset_n;
    int   total;
    int   bad;
    int   cyc;
    logic [31:0] eq;
    logic [31:0] er;
    logic [31:0] eres;

    iter_divider_if #(.WIDTH(32)) bus ();

    iter_divider #(
        .WIDTH (32)
    ) dut (
        .clk_i    (clk),
        .reset_ni (reset_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic; SV / and % truncate toward zero like RISC-V
    function automatic void model(input logic [1:0] op, input logic [31:0] a,
                                  input logic [31:0] b, output logic [31:0] q,
                                  output logic [31:0] r, output logic [31:0] res,
                                  output int lat);
        longint sa, sb, lq, lr;
        if (b == 32'd0) begin
            q   = 32'hFFFF_FFFF;
            r   = a;
            lat = 2;
        end else begin
            if (op[0] == 1'b0) begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
            end else begin
                sa = longint'({32'd0, a});
                sb = longint'({32'd0, b});
            end
            lq  = sa / sb;
            lr  = sa % sb;
            q   = lq[31:0];
            r   = lr[31:0];
            lat = (op[0] == 1'b0 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 2 : 35;
        end
        res = op[1] ? r : q;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.start_i    = 1'b1;
        bus.op_i       = op;
        bus.dividend_i = a;
        bus.divisor_i  = b;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        cyc = 1;
    endtask

    task automatic wait_done(input int limit, output int dcyc, output int rhi);
        rhi = 0;
        while (bus.done_o !== 1'b1 && cyc < limit) begin
            if (bus.ready_o !== 1'b0) rhi++;
            step();
        end
        dcyc = (bus.done_o === 1'b1) ? cyc : -1;
    endtask

    // Called in cycle 1 of an accepted op; checks latency, busy window, results, pulse width
    task automatic finish_check(input string tag, input logic [1:0] op, input logic [31:0] a,
                                input logic [31:0] b, input bit check_pulse);
        int lat, dcyc, rhi;
        model(op, a, b, eq, er, eres, lat);
        wait_done(80, dcyc, rhi);
        chk({tag, ".lat"}, 64'(dcyc), 64'(lat));
        chk({tag, ".busy"}, 64'(rhi), 64'd0);
        chk({tag, ".q"}, 64'(bus.quotient_o), 64'(eq));
        chk({tag, ".r"}, 64'(bus.remainder_o), 64'(er));
        chk({tag, ".res"}, 64'(bus.result_o), 64'(eres));
        if (check_pulse) begin
            step();
            chk({tag, ".pulse"}, 64'(bus.done_o), 64'd0);
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b);
        launch(op, a, b);
        finish_check(tag, op, a, b, 1'b1);
    endtask

    initial begin
        int          dones;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int unsigned mode;

        total = 0;
        bad   = 0;
        cyc   = 0;
        reset_n        = 1'b0;
        bus.start_i    = 1'b0;
        bus.op_i       = 2'b00;
        bus.dividend_i = '0;
        bus.divisor_i  = '0;
        bus.flush_i    = 1'b0;

        // Reset state, both during and after reset
        #3;
        chk("rst.ready", 64'(bus.ready_o), 64'd1);
        chk("rst.done", 64'(bus.done_o), 64'd0);
        chk("rst.q", 64'(bus.quotient_o), 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        step();
        chk("post.ready", 64'(bus.ready_o), 64'd1);
        chk("post.r", 64'(bus.remainder_o), 64'd0);
        chk("post.res", 64'(bus.result_o), 64'd0);

        // 1: basic unsigned
        run_op("divu100_7", 2'b01, 32'd100, 32'd7);
        chk("t1.q", 64'(bus.quotient_o), 64'd14);
        chk("t1.r", 64'(bus.remainder_o), 64'd2);

        // 2: signed sign rules
        run_op("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2);
        chk("t2a.q", 64'(bus.quotient_o), 64'hFFFF_FFFD);
        chk("t2a.r", 64'(bus.remainder_o), 64'hFFFF_FFFF);
        run_op("rem_7_m2", 2'b10, 32'd7, 32'hFFFF_FFFE);
        chk("t2b.res", 64'(bus.result_o), 64'd1);
        run_op("div_m7_m2", 2'b00, 32'hFFFF_FFF9, 32'hFFFF_FFFE);
        chk("t2c.q", 64'(bus.quotient_o), 64'd3);
        chk("t2c.r", 64'(bus.remainder_o), 64'hFFFF_FFFF);

        // 3: divide by zero
        run_op("divu_z", 2'b01, 32'h1234, 32'd0);
        chk("t3a.q", 64'(bus.quotient_o), 64'hFFFF_FFFF);
        chk("t3a.r", 64'(bus.remainder_o), 64'h1234);
        run_op("div_z", 2'b00, 32'hFFFF_FFF9, 32'd0);
        chk("t3b.r", 64'(bus.remainder_o), 64'hFFFF_FFF9);

        // 4: signed overflow
        run_op("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("t4a.q", 64'(bus.quotient_o), 64'h8000_0000);
        run_op("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("t4b.res", 64'(bus.result_o), 64'd0);

        // 5: flush mid-ITER, outputs keep the overflow REM results
        launch(2'b01, 32'd1000, 32'd3);
        while (cyc < 10) step();
        bus.flush_i = 1'b1;
        step();
        bus.flush_i = 1'b0;
        chk("flush.ready", 64'(bus.ready_o), 64'd1);
        chk("flush.done", 64'(bus.done_o), 64'd0);
        chk("flush.q", 64'(bus.quotient_o), 64'(eq));
        chk("flush.res", 64'(bus.result_o), 64'(eres));
        dones = 0;
        repeat (40) begin
            if (bus.done_o !== 1'b0) dones++;
            step();
        end
        chk("flush.nodone", 64'(dones), 64'd0);

        // 5b: REMU 50/5 with start held through DONE, then back-to-back DIVU 81/9
        @(negedge clk);
        bus.start_i    = 1'b1;
        bus.op_i       = 2'b11;
        bus.dividend_i = 32'd50;
        bus.divisor_i  = 32'd5;
        @(posedge clk);
        #1;
        cyc = 1;
        bus.op_i       = 2'b01;
        bus.dividend_i = 32'd81;
        bus.divisor_i  = 32'd9;
        finish_check("remu50_5", 2'b11, 32'd50, 32'd5, 1'b0);
        step();
        cyc = 1;
        bus.start_i = 1'b0;
        chk("b2b.busy0", 64'(bus.ready_o), 64'd0);
        finish_check("b2b_divu81_9", 2'b01, 32'd81, 32'd9, 1'b1);

        // 6: async reset mid-ITER
        launch(2'b01, 32'hFFFF_FFFF, 32'd1);
        while (cyc < 15) step();
        reset_n = 1'b0;
        #1;
        chk("arst.ready", 64'(bus.ready_o), 64'd1);
        chk("arst.done", 64'(bus.done_o), 64'd0);
        chk("arst.q", 64'(bus.quotient_o), 64'd0);
        chk("arst.r", 64'(bus.remainder_o), 64'd0);
        chk("arst.res", 64'(bus.result_o), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // 6b: start pulse while busy is ignored
        launch(2'b01, 32'd77, 32'd7);
        while (cyc < 5) step();
        bus.start_i    = 1'b1;
        bus.op_i       = 2'b00;
        bus.dividend_i = 32'd5;
        bus.divisor_i  = 32'd0;
        step();
        bus.start_i = 1'b0;
        finish_check("ignore", 2'b01, 32'd77, 32'd7, 1'b1);

        // Random ops against the reference model
        for (int i = 0; i < 30; i++) begin
            op   = 2'($urandom_range(0, 3));
            a    = $urandom;
            b    = $urandom;
            mode = $urandom_range(0, 9);
            if (mode == 0) begin
                b = 32'd0;
            end else if (mode == 1) begin
                a = 32'h8000_0000;
                b = 32'hFFFF_FFFF;
            end else if (mode < 5) begin
                b = 32'($urandom_range(1, 20));
                if (mode == 4) b = -b;
            end
            run_op($sformatf("rnd%0d", i), op, a, b);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/iter_divider.md
Name: iter_divider

Overview:
- Parametrised multi-cycle integer divider for the execute stage; successor to the fixed 32-bit unsigned divider.
- Supports the signed and unsigned RISC-V M-extension ops DIV, DIVU, REM and REMU.
- Adds a ready/start handshake, a flush input, and RISC-V-defined divide-by-zero and overflow results.
- Uses radix-2 restoring division, one quotient bit per cycle, with short-cut paths for the special cases.

Parameters:
WIDTH, 32, operand/result width in bits; legal values 4..64.

Ports:
clk_i  in  1  clock; all state changes on the rising edge
reset_ni  in  1  asynchronous, active-low reset
start_i  in  1  request; accepted on a rising edge only while ready_o=1
op_i  in  2  00=DIV, 01=DIVU, 10=REM, 11=REMU (funct3[1:0]); sampled with start_i
dividend_i  in  WIDTH  dividend; sampled with start_i
divisor_i  in  WIDTH  divisor; sampled with start_i
flush_i  in  1  abandons any in-flight operation
ready_o  out  1  high in IDLE and DONE
quotient_o  out  WIDTH  quotient of the last completed operation
remainder_o  out  WIDTH  remainder of the last completed operation
done_o  out  1  one-cycle pulse; quotient_o/remainder_o valid in that cycle
result_o  out  WIDTH  quotient_o for DIV/DIVU, remainder_o for REM/REMU (op of the last completed operation)

Behaviour:
- Reset (reset_ni=0, asynchronous):
  - state=IDLE, ready_o=1, done_o=0.
  - quotient_o, remainder_o and result_o all 0.
  - Reset may occur in any state, including mid-ITER; no partial result survives it.
- States: IDLE, PREP, ITER, FIX, DONE.
- IDLE:
  - start_i=1 at an edge → latch op and operands → PREP.
- PREP (1 cycle):
  - Signed ops: take |dividend| and |divisor|; record neg_q = sign(dividend) XOR sign(divisor), neg_r = sign(dividend).
  - Divisor==0 → quotient = all ones, remainder = dividend (both ops classes) → DONE.
  - Signed overflow (dividend = 100..0, divisor = all ones) → quotient = dividend, remainder = 0 → DONE.
  - Otherwise: clear partial remainder, counter = WIDTH-1 → ITER.
- ITER (WIDTH cycles):
  - Each cycle: shift in the next dividend bit (MSB first), trial-subtract the divisor on a WIDTH+1-bit datapath, set the quotient bit if the result is non-negative, otherwise restore.
  - Counter==0 → FIX.
- FIX (1 cycle):
  - Negate the quotient if neg_q; negate the remainder if neg_r. Unsigned ops pass through.
  - → DONE.
- DONE (1 cycle):
  - done_o=1; outputs updated.
  - Next edge: start_i=1 → PREP (back-to-back operation), else → IDLE.
- Latency (start accepted at edge 0):
  - Normal: done_o high in cycle WIDTH+3.
  - Zero-divisor or overflow: done_o high in cycle 2.
- Output holding: quotient_o, remainder_o and result_o hold their values until the next DONE; they are not cleared on IDLE.
- Handshake rules:
  - start_i while ready_o=0 is ignored; no queueing.
  - flush_i=1 in PREP/ITER/FIX/DONE → IDLE at the next edge; done_o suppressed; outputs keep their prior values.
  - flush_i and start_i in the same cycle: flush wins, start is dropped.
  - flush_i in IDLE has no effect.
- Result sign rules: the remainder sign follows the dividend; the quotient truncates toward zero.

Decomposition:
- Shared package div_pkg holds:
  - div_op_e enum (DIV, DIVU, REM, REMU).
  - div_state_e enum.
  - Helper function is_signed(op).
- One sub-module, div_step: a combinational one-bit restoring step parametrised by WIDTH.
  - Inputs: partial remainder, next dividend bit, divisor.
  - Outputs: new partial remainder, quotient bit.

Test Plan:
1. WIDTH=32, DIVU 100/7 → quotient_o=14, remainder_o=2, done_o pulse exactly in cycle 35, ready_o low in cycles 1..34.
2. DIV 0xFFFFFFF9 (-7) / 2 → q=0xFFFFFFFD, r=0xFFFFFFFF; REM 7 / 0xFFFFFFFE (-2) → result_o=1; DIV -7/-2 → q=3, r=0xFFFFFFFF.
3. DIVU 0x1234/0 → q=0xFFFFFFFF, r=0x1234, done_o in cycle 2; DIV 0xFFFFFFF9/0 → q=0xFFFFFFFF, r=0xFFFFFFF9.
4. DIV 0x80000000 / 0xFFFFFFFF → q=0x80000000, r=0, done_o in cycle 2; REM of the same operands → result_o=0.
5. Start 1000/3, flush_i in cycle 10 → ready_o=1 in cycle 11, no done_o, outputs unchanged. Then start REMU 50/5 held through the DONE cycle → r=0, and a second op launches back-to-back from DONE.
6. Start 0xFFFFFFFF/1, pull reset_ni low in cycle 15 → ready_o=1, done_o=0 and all outputs 0 immediately. A start_i pulse in cycle 5 of a separate op → ignored, that op completes with its original operands.
